// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial CLA subtractor: FSM state encoding and slice width.
package cla_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/cla_slice4.sv
// 4-bit carry-look-ahead adder slice: s = a + b + cin, with generate/propagate look-ahead carries.
module cla_slice4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        s    = p ^ c[3:0];
        cout = c[4];
    end

endmodule

// File: rtl/cla_nibble_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin mod 2^WIDTH, one 4-bit CLA slice per clock,
// computed as a + ~b + ~bin with the carry registered between slices.
module cla_nibble_serial_subtractor
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NIBBLES = WIDTH / SLICE_W;
    localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   nb_q, nb_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;

    logic [SLICE_W-1:0] sl_a, sl_b, sl_s;
    logic               sl_cout;

    assign sl_a = a_q[idx_q*SLICE_W +: SLICE_W];
    assign sl_b = nb_q[idx_q*SLICE_W +: SLICE_W];

    cla_slice4 u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_q),
        .s    (sl_s),
        .cout (sl_cout)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        a_d       = a_q;
        nb_d      = nb_q;
        diff_d    = diff_q;
        bout_d    = bout_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    nb_d    = ~b;
                    carry_d = ~bin;
                    idx_d   = '0;
                    diff_d  = '0;
                    bout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    zero_d  = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                diff_d[idx_q*SLICE_W +: SLICE_W] = sl_s;
                carry_d = sl_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    // Flags use the fully assembled result including this final slice.
                    bout_d  = ~sl_cout;
                    ovf_d   = (a_q[WIDTH-1] ^ ~nb_q[WIDTH-1]) & (diff_d[WIDTH-1] ^ a_q[WIDTH-1]);
                    zero_d  = ~|diff_d;
                    idx_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            nb_q    <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            nb_q    <= nb_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_cla_nibble_serial_subtractor.sv
// Self-checking bench for cla_nibble_serial_subtractor (WIDTH=16) against an arithmetic model.
module tb_cla_nibble_serial_subtractor;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cla_nibble_serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    // Returns {zero, ovf, bout, diff} from plain integer arithmetic.
    function automatic logic [18:0] model(logic [15:0] x, logic [15:0] y, logic c);
        int          r;
        logic [15:0] d;
        logic        bo, ov, z;
        r  = int'(x) - int'(y) - int'(c);
        d  = r[15:0];
        bo = int'(x) < (int'(y) + int'(c));
        ov = (x[15] != y[15]) && (d[15] != x[15]);
        z  = (d == 16'h0000);
        return {z, ov, bo, d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one operand set, waits for out_valid; lat = edges after the accepting edge.
    task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic c,
                          output int lat);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        bin      = c;
        step();
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        bin      = 1'($urandom);
        lat      = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic release_op();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        a         = 16'hFFFF;
        b         = 16'h0001;
        bin       = 1'b0;
        step();
        step();
        total++;
        if ({out_valid, diff, bout, ovf, zero} !== 20'h0) begin
            bad++;
            $display("FAIL reset_outputs: got ov=%b d=%h b=%b o=%b z=%b want all 0",
                     out_valid, diff, bout, ovf, zero);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_out_valid: got %b want 0", out_valid);
        end
    endtask

    task automatic test_directed();
        logic [15:0] va [6] = '{16'h1234, 16'h0000, 16'h0005, 16'h8000, 16'hBEEF, 16'h0000};
        logic [15:0] vb [6] = '{16'h0034, 16'h0001, 16'h0005, 16'h0001, 16'hBEEF, 16'h0000};
        logic        vc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [18:0] exp;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            exp = model(va[i], vb[i], vc[i]);
            run_op(va[i], vb[i], vc[i], lat);
            total++;
            if (lat !== 4) begin
                bad++;
                $display("FAIL directed_latency[%0d]: got %0d want 4", i, lat);
            end
            total++;
            if ({zero, ovf, bout, diff} !== exp) begin
                bad++;
                $display("FAIL directed_result[%0d]: got z=%b o=%b b=%b d=%h want z=%b o=%b b=%b d=%h",
                         i, zero, ovf, bout, diff, exp[18], exp[17], exp[16], exp[15:0]);
            end
            release_op();
        end
    endtask

    task automatic test_random();
        logic [15:0] x, y;
        logic        c;
        logic [18:0] exp;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            x = 16'($urandom);
            y = (i % 8 == 0) ? x : 16'($urandom);
            c = (i % 8 == 0) ? 1'b0 : 1'($urandom);
            exp = model(x, y, c);
            run_op(x, y, c, lat);
            total++;
            if (lat !== 4 || {zero, ovf, bout, diff} !== exp) begin
                bad++;
                $display("FAIL random[%0d] %h-%h-%b: got lat=%0d z=%b o=%b b=%b d=%h want lat=4 %h",
                         i, x, y, c, lat, zero, ovf, bout, diff, exp);
            end
            // Random extra idle cycles before the consumer takes the result.
            repeat ($urandom_range(0, 2)) step();
            release_op();
        end
    endtask

    task automatic test_backpressure();
        logic [18:0] exp;
        int          lat;
        exp = model(16'h4321, 16'h1234, 1'b1);
        run_op(16'h4321, 16'h1234, 1'b1, lat);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = 16'h0F0F;
            b        = 16'h00FF;
            bin      = 1'b0;
            step();
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {zero, ovf, bout, diff} !== exp) begin
                bad++;
                $display("FAIL backpressure_hold[%0d]: got ov=%b ir=%b res=%h want ov=1 ir=0 res=%h",
                         i, out_valid, in_ready, {zero, ovf, bout, diff}, exp);
            end
        end
        in_valid = 1'b0;
        release_op();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || {zero, ovf, bout, diff} !== exp) begin
            bad++;
            $display("FAIL backpressure_release: got ir=%b ov=%b res=%h want ir=1 ov=0 res=%h",
                     in_ready, out_valid, {zero, ovf, bout, diff}, exp);
        end
        exp = model(16'h0F0F, 16'h00FF, 1'b0);
        run_op(16'h0F0F, 16'h00FF, 1'b0, lat);
        total++;
        if (lat !== 4 || {zero, ovf, bout, diff} !== exp) begin
            bad++;
            $display("FAIL backpressure_next_op: got lat=%0d res=%h want lat=4 res=%h",
                     lat, {zero, ovf, bout, diff}, exp);
        end
        release_op();
    endtask

    task automatic test_reset_midop();
        int seen = 0;
        int lat;
        in_valid = 1'b1;
        a        = 16'h1234;
        b        = 16'h0034;
        bin      = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || diff !== 16'h0000 || bout !== 1'b0) begin
            bad++;
            $display("FAIL midop_reset_clear: got ov=%b d=%h b=%b want 0 0000 0",
                     out_valid, diff, bout);
        end
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            step();
        end
        total++;
        if (seen != 0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midop_no_result: got out_valid_cycles=%0d ir=%b want 0 1", seen, in_ready);
        end
        run_op(16'h0010, 16'h0001, 1'b0, lat);
        total++;
        if (lat !== 4 || diff !== 16'h000F || bout !== 1'b0) begin
            bad++;
            $display("FAIL midop_next_op: got lat=%0d d=%h b=%b want 4 000f 0", lat, diff, bout);
        end
        release_op();
    endtask

    task automatic test_back_to_back();
        logic [18:0] exp_q[$];
        int          acc_q[$];
        int          checked = 0;
        int          lat;
        logic [18:0] e;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 16'($urandom);
        b         = 16'($urandom);
        bin       = 1'($urandom);
        for (int edge_n = 0; edge_n < 14; edge_n++) begin
            if (out_valid) begin
                e = exp_q.pop_front();
                checked++;
                total++;
                if ({zero, ovf, bout, diff} !== e) begin
                    bad++;
                    $display("FAIL b2b_result: got %h want %h", {zero, ovf, bout, diff}, e);
                end
            end
            if (in_ready) begin
                acc_q.push_back(edge_n);
                exp_q.push_back(model(a, b, bin));
            end
            step();
            if (acc_q.size() > 0 && acc_q[acc_q.size()-1] == edge_n) begin
                a   = 16'($urandom);
                b   = 16'($urandom);
                bin = 1'($urandom);
            end
        end
        in_valid = 1'b0;
        total++;
        if (acc_q.size() != 3 || acc_q[0] != 0 || acc_q[1] != 6 || acc_q[2] != 12 || checked != 2)
        begin
            bad++;
            $display("FAIL b2b_throughput: got accepts=%p results=%0d want '{0,6,12} 2",
                     acc_q, checked);
        end
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        total++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 19'h0;
        if (!out_valid || {zero, ovf, bout, diff} !== e) begin
            bad++;
            $display("FAIL b2b_drain: got ov=%b res=%h want ov=1 res=%h",
                     out_valid, {zero, ovf, bout, diff}, e);
        end
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
